// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT core scheduler.
//   NTT_N         : coefficients per job
//   coef_t        : one coefficient / result word
//   sched_state_e : scheduler FSM states
//   next_idx()    : requester index increment, wrapping at the requester count
package ntt_pkg;

  localparam int unsigned NTT_N   = 256;
  localparam int unsigned COEF_W  = 32;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 9;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    S_ARB,
    S_LOAD,
    S_WAIT,
    S_UNLOAD,
    S_RECOVER
  } sched_state_e;

  // Index of the requester after idx, wrapping modulo n.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input int unsigned       n);
    return (32'(idx) == (n - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping modulo NUM_REQ.
//   req_i   : request vector
//   ptr_i   : search start index (must be < NUM_REQ)
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the granted requester
//   valid_o : at least one request present
module rr_arbiter
  import ntt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [MAX_REQ-1:0] req_ext;
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   cand;

  // Walk the candidates in priority order; the first hit wins.
  always_comb begin
    req_ext = MAX_REQ'(req_i);
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!valid_o && req_ext[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  assign gnt_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/ntt_sched.sv
// Round-robin scheduler sharing one ntt core among NUM_REQ requesters.
// A job: grant one requester, stream its 256 coefficients into the core,
// route the 256 results back to it; a watchdog resets a hung core.
//   i_req / i_req_intt       : job request and inverse flag per requester
//   i_req_valid / i_req_data : coefficient stream per requester (32 b lanes)
//   o_req_ready              : coefficient accepted, one-hot to owner
//   o_gnt                    : registered one-hot grant, held for the job
//   o_rsp_valid / o_rsp_data : result word, valid one-hot, data broadcast
//   o_busy, o_err, o_err_id  : status, watchdog pulse, owner at last error
//   o_ntt_*, i_ntt_*         : core-side handshake, data and reset pulse
module ntt_sched
  import ntt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_req_intt,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [COEF_W*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  output logic [COEF_W-1:0]           o_rsp_data,
  output logic                        o_busy,
  output logic                        o_err,
  output logic [IDX_W-1:0]            o_err_id,
  output logic                        o_ntt_ready,
  output logic                        o_ntt_intt,
  output logic [COEF_W-1:0]           o_ntt_data,
  input  logic                        i_ntt_valid,
  input  logic [COEF_W-1:0]           i_ntt_data,
  output logic                        o_ntt_rst
);

  localparam int unsigned      WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTT_N - 1);

  sched_state_e         state_q;
  logic [IDX_W-1:0]     owner_q;
  logic                 intt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WD_W-1:0]      wdog_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 err_q;
  logic [IDX_W-1:0]     err_id_q;
  logic                 ntt_rst_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;

  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_REQ-1:0]   intt_ext;
  coef_t                owner_data;
  logic                 load_acc;
  logic                 core_word;
  logic                 wdog_expire;
  logic [IDX_W-1:0]     ptr_after_owner;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Owner-lane selection; widened so the 3-bit owner index always fits.
  assign valid_ext       = MAX_REQ'(i_req_valid);
  assign intt_ext        = MAX_REQ'(i_req_intt);
  assign owner_data      = coef_t'(i_req_data >> (COEF_W * 32'(owner_q)));
  assign load_acc        = (state_q == S_LOAD) && valid_ext[owner_q];
  // Core output only counts once the load is complete; earlier pulses are spurious.
  assign core_word       = ((state_q == S_WAIT) || (state_q == S_UNLOAD)) && i_ntt_valid;
  assign wdog_expire     = (wdog_q == WD_LAST);
  assign ptr_after_owner = next_idx(owner_q, NUM_REQ);

  // Scheduler FSM, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_ARB;
      owner_q   <= '0;
      intt_q    <= 1'b0;
      cnt_q     <= '0;
      wdog_q    <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      ntt_rst_q <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      ntt_rst_q <= 1'b0;
      case (state_q)
        S_ARB: begin
          if (arb_valid) begin
            owner_q <= arb_idx;
            intt_q  <= intt_ext[arb_idx];
            gnt_q   <= arb_gnt;
            cnt_q   <= '0;
            wdog_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_acc) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              wdog_q  <= '0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_WAIT, S_UNLOAD: begin
          if (core_word) begin
            wdog_q <= '0;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              gnt_q   <= '0;
              ptr_q   <= ptr_after_owner;
              state_q <= S_ARB;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= S_UNLOAD;
            end
          end else if (wdog_expire) begin
            // TIMEOUT cycles with no result word: abandon the job.
            wdog_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b1;
            ntt_rst_q <= 1'b1;
            err_id_q  <= owner_q;
            gnt_q     <= '0;
            ptr_q     <= ptr_after_owner;
            state_q   <= S_RECOVER;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_RECOVER: begin
          state_q <= S_ARB;
        end
        default: begin
          state_q <= S_ARB;
        end
      endcase
    end
  end

  // Combinational data paths: load steering and zero-latency result routing.
  always_comb begin
    o_req_ready = '0;
    o_ntt_ready = 1'b0;
    o_ntt_data  = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    case (state_q)
      S_LOAD: begin
        o_req_ready = NUM_REQ'(1) << owner_q;
        o_ntt_ready = valid_ext[owner_q];
        o_ntt_data  = owner_data;
      end
      S_WAIT, S_UNLOAD: begin
        if (i_ntt_valid) begin
          o_rsp_valid = NUM_REQ'(1) << owner_q;
          o_rsp_data  = i_ntt_data;
        end
      end
      default: ;
    endcase
  end

  assign o_gnt      = gnt_q;
  assign o_busy     = (state_q != S_ARB);
  assign o_err      = err_q;
  assign o_err_id   = err_id_q;
  assign o_ntt_rst  = ntt_rst_q;
  assign o_ntt_intt = (state_q != S_ARB) && intt_q;

endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: stimulus pushes expected core-side and
// requester-side words into queues; monitors pop and compare on each event.
module tb_ntt_sched;
  import ntt_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 100;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [NR-1:0]   i_req, i_req_intt, i_req_valid;
  logic [32*NR-1:0] i_req_data;
  logic [NR-1:0]   o_req_ready, o_gnt, o_rsp_valid;
  logic [31:0]     o_rsp_data, o_ntt_data, i_ntt_data;
  logic            o_busy, o_err, o_ntt_ready, o_ntt_intt, i_ntt_valid, o_ntt_rst;
  logic [2:0]      o_err_id;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt = 0;
  int rsp_cnt   = 0;
  logic          cur_intt = 1'b0;
  logic [NR-1:0] cur_oh   = '0;
  logic [32:0]   ld_q[$];   // {intt, data} expected at the core input
  logic [33:0]   rsp_q[$];  // {owner one-hot, data} expected at the requesters

  ntt_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_req_intt  (i_req_intt),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_gnt       (o_gnt),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_err_id    (o_err_id),
    .o_ntt_ready (o_ntt_ready),
    .o_ntt_intt  (o_ntt_intt),
    .o_ntt_data  (o_ntt_data),
    .i_ntt_valid (i_ntt_valid),
    .i_ntt_data  (i_ntt_data),
    .o_ntt_rst   (o_ntt_rst)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core-side monitor.
  always @(negedge i_clk) begin
    logic [32:0] e;
    if (!i_rst && o_ntt_ready) begin
      ready_cnt++;
      if (ld_q.size() == 0) chk("ntt_ready_unexpected", 1, 0);
      else begin
        e = ld_q.pop_front();
        chk("ntt_data", o_ntt_data, e[31:0]);
        chk("ntt_intt", o_ntt_intt, e[32]);
        chk("req_ready", o_req_ready, cur_oh);
      end
    end
    if (!i_rst && o_gnt != '0) chk("ntt_intt_hold", o_ntt_intt, cur_intt);
  end

  // Requester-side monitor.
  always @(negedge i_clk) begin
    logic [33:0] e;
    if (!i_rst && o_rsp_valid != '0) begin
      rsp_cnt++;
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_owner", o_rsp_valid, e[33:32]);
        chk("rsp_data", o_rsp_data, e[31:0]);
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_err_id"}, o_err_id, 0);
    chk({tag, "_ntt_rst"}, o_ntt_rst, 0);
    chk({tag, "_req_ready"}, o_req_ready, 0);
    chk({tag, "_ntt_ready"}, o_ntt_ready, 0);
    chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
    chk({tag, "_ntt_intt"}, o_ntt_intt, 0);
    chk({tag, "_ntt_data"}, o_ntt_data, 0);
  endtask

  // One job for requester r. mode 0: core answers, 1: core hangs,
  // 2: core answers 37 words then returns (caller resets).
  task automatic serve(input logic [0:0] r, input logic intt, input logic gapped,
                       input logic spur, input int mode, input int exp_lat);
    int lat, k, cyc, n;
    logic [NR-1:0] oh;
    logic [31:0]   d;
    oh = NR'(1) << r;
    i_req_intt[r] = intt;
    lat = 0;
    while (o_gnt == '0 && lat < 50) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk("gnt_owner", o_gnt, oh);
    if (exp_lat > 0) chk("gnt_latency", lat, exp_lat);
    chk("busy_in_job", o_busy, 1);
    i_req[r]      = 1'b0;
    i_req_intt[r] = ~intt;       // flag must have been captured at the grant
    cur_intt      = intt;
    cur_oh        = oh;
    ready_cnt     = 0;
    k = 0; cyc = 0;
    while (k < 256 && cyc < 600) begin
      if (gapped && (cyc % 2) == 1) i_req_valid[r] = 1'b0;
      else begin
        d = (32'(r) + 32'd1) << 28 | 32'(k);
        i_req_valid[r] = 1'b1;
        i_req_data[32*r +: 32] = d;
        ld_q.push_back({intt, d});
        k++;
      end
      i_ntt_valid = spur && (cyc == 10);
      i_ntt_data  = 32'hEEEE_0000;
      @(posedge i_clk); #1;
      cyc++;
    end
    i_req_valid[r] = 1'b0;
    i_ntt_valid    = 1'b0;
    chk("load_cycles", cyc, gapped ? 511 : 256);
    chk("load_words", ready_cnt, 256);
    chk("ld_q_empty", ld_q.size(), 0);
    chk("req_ready_after_load", o_req_ready, 0);
    rsp_cnt = 0;
    if (mode == 1) begin
      i_req[~r] = 1'b1;          // another requester arrives while the core is hung
      n = 0;
      while (!o_err && n < 300) begin
        @(posedge i_clk); #1;
        n++;
      end
      chk("wdog_cycles", n, TO);
      chk("err_id", o_err_id, 64'(r));
      chk("ntt_rst_pulse", o_ntt_rst, 1);
      chk("rsp_during_hang", rsp_cnt, 0);
      @(posedge i_clk); #1;
      chk("err_clear", o_err, 0);
      chk("ntt_rst_clear", o_ntt_rst, 0);
      chk("err_id_held", o_err_id, 64'(r));
    end else begin
      repeat (3) begin @(posedge i_clk); #1; end
      for (int w = 0; w < 256; w++) begin
        if (mode == 2 && w == 37) break;
        i_ntt_valid = 1'b1;
        i_ntt_data  = 32'hC000_0000 | (32'(r) << 20) | 32'(w * 3);
        rsp_q.push_back({oh, i_ntt_data});
        @(posedge i_clk); #1;
      end
      i_ntt_valid = 1'b0;
      if (mode == 0) begin
        chk("rsp_words", rsp_cnt, 256);
        chk("busy_after_job", o_busy, 0);
        chk("gnt_after_job", o_gnt, 0);
      end else begin
        chk("rsp_words_partial", rsp_cnt, 37);
        chk("busy_mid_unload", o_busy, 1);
      end
      chk("rsp_q_empty", rsp_q.size(), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    i_rst = 1'b1;
    i_req = '0; i_req_intt = '0; i_req_valid = '0;
    i_req_data = {32'hBAD1_BAD1, 32'hBAD0_BAD0};
    i_ntt_valid = 1'b0; i_ntt_data = '0;
    repeat (2) begin @(posedge i_clk); #1; end
    chk_idle("reset");
    i_rst = 1'b0;
    // Core valid while idle must be ignored.
    i_ntt_valid = 1'b1; i_ntt_data = 32'h1234_5678;
    @(posedge i_clk); #1;
    chk_idle("idle_spurious");
    i_ntt_valid = 1'b0;

    // Contention after reset: r0 then r1 (r1 gapped, inverse).
    i_req = 2'b11;
    serve(1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
    serve(1'b1, 1'b1, 1'b1, 1'b0, 0, 1);

    // Single r0 job, then contention with pointer at 1: r1 first.
    @(posedge i_clk); #1;
    i_req = 2'b01;
    serve(1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    @(posedge i_clk); #1;
    i_req = 2'b11;
    serve(1'b1, 1'b1, 1'b0, 1'b0, 0, 1);
    serve(1'b0, 1'b0, 1'b0, 1'b0, 0, 1);

    // Watchdog on r1, pending r0 served afterwards.
    @(posedge i_clk); #1;
    i_req = 2'b10;
    serve(1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
    serve(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);

    // Reset at unload word 37 of an r1 job (pointer is 1 here).
    @(posedge i_clk); #1;
    i_req = 2'b10;
    serve(1'b1, 1'b1, 1'b0, 1'b0, 2, 1);
    i_rst = 1'b1;
    #1;
    chk_idle("mid_reset");
    ld_q.delete(); rsp_q.delete();
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;

    // Pointer back to 0: r0 wins over r1, then r1 served normally.
    @(posedge i_clk); #1;
    i_req = 2'b11;
    serve(1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    serve(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);

    repeat (2) begin @(posedge i_clk); #1; end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
